// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encodings,
// forwarding select codes and the active level of the pipeline-register flush.
package hazard_pkg;

    typedef logic [1:0] state_t;

    localparam state_t RUN      = 2'd0;
    localparam state_t MEM_WAIT = 2'd1;
    localparam state_t HALT     = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic CLR_ACTIVE = 1'b0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the core datapath and the hazard controller. The perf
// counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    // No valid/ready pair here: mem_busy is a level hold request from data
    // memory; while it is high the MEM stage must not advance.
    logic              en;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_is_load;
    logic              ex_redirect;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              mem_regwrite;
    logic              wb_regwrite;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              mem_busy;
    logic              wb_halt;

    logic              pc_en;
    logic              en_vps1, en_vps2, en_vps3, en_vps4;
    logic              clear_vps1, clear_vps2, clear_vps3, clear_vps4;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              halted;
    logic              timeout_err;
    logic [1:0]        state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  perf_stall_cnt;
    logic [CNT_W-1:0]  perf_flush_cnt;
`endif

    modport master (
        output en, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_redirect, mem_rd, wb_rd, mem_regwrite, wb_regwrite,
               ex_rs1, ex_rs2, mem_busy, wb_halt,
        input  pc_en, en_vps1, en_vps2, en_vps3, en_vps4,
               clear_vps1, clear_vps2, clear_vps3, clear_vps4,
               fwd_a, fwd_b, halted, timeout_err, state
`ifdef HAZARD_PERF_CNT_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  en, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_redirect, mem_rd, wb_rd, mem_regwrite, wb_regwrite,
               ex_rs1, ex_rs2, mem_busy, wb_halt,
        output pc_en, en_vps1, en_vps2, en_vps3, en_vps4,
               clear_vps1, clear_vps2, clear_vps3, clear_vps4,
               fwd_a, fwd_b, halted, timeout_err, state
`ifdef HAZARD_PERF_CNT_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX operand forwarding compare for one source operand; MEM beats WB and
// x0 is never forwarded.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32 pipeline.
// Optional saturating perf counters are enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W+1)'(TIMEOUT);

    state_t           state, state_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             timeout_err_q, timeout_err_n;
    logic [CNT_W:0]   cnt_inc;
    logic             load_use;
    logic             active;
    logic             pc_en_c;
    logic [3:0]       en_c;
    logic [3:0]       clr_c;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    assign active   = (state != HALT);
    assign load_use = bus.ex_is_load && (bus.ex_rd != '0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign cnt_inc  = {1'b0, wait_cnt} + 1'b1;

    // Bit 0 is the IF/ID register, bit 3 the MEM/WB register.
    always_comb begin
        pc_en_c = 1'b1;
        en_c    = 4'b1111;
        clr_c   = 4'b1111;
        if (!rst_n) begin
            pc_en_c = 1'b0;
            en_c    = 4'b0000;
            clr_c   = {4{CLR_ACTIVE}};
        end else if (!bus.en || !active) begin
            pc_en_c = 1'b0;
            en_c    = 4'b0000;
        end else if (bus.mem_busy) begin
            pc_en_c  = 1'b0;
            en_c     = 4'b1000;
            clr_c[3] = CLR_ACTIVE;
        end else if (bus.ex_redirect) begin
            clr_c[0] = CLR_ACTIVE;
            clr_c[1] = CLR_ACTIVE;
        end else if (load_use) begin
            pc_en_c  = 1'b0;
            en_c[0]  = 1'b0;
            clr_c[1] = CLR_ACTIVE;
        end
    end

    always_comb begin
        state_n       = state;
        wait_cnt_n    = wait_cnt;
        timeout_err_n = timeout_err_q;
        if (bus.en && active) begin
            if (bus.wb_halt) begin
                state_n = HALT;
            end else if (bus.mem_busy) begin
                wait_cnt_n = cnt_inc[CNT_W-1:0];
                if (cnt_inc >= TIMEOUT_V) begin
                    timeout_err_n = 1'b1;
                    state_n       = HALT;
                end else begin
                    state_n = MEM_WAIT;
                end
            end else begin
                state_n    = RUN;
                wait_cnt_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            wait_cnt      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state         <= state_n;
            wait_cnt      <= wait_cnt_n;
            timeout_err_q <= timeout_err_n;
        end
    end

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs           (bus.ex_rs1),
        .mem_rd       (bus.mem_rd),
        .mem_regwrite (bus.mem_regwrite),
        .wb_rd        (bus.wb_rd),
        .wb_regwrite  (bus.wb_regwrite),
        .sel          (fwd_a_raw)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs           (bus.ex_rs2),
        .mem_rd       (bus.mem_rd),
        .mem_regwrite (bus.mem_regwrite),
        .wb_rd        (bus.wb_rd),
        .wb_regwrite  (bus.wb_regwrite),
        .sel          (fwd_b_raw)
    );

    assign bus.pc_en       = pc_en_c;
    assign bus.en_vps1     = en_c[0];
    assign bus.en_vps2     = en_c[1];
    assign bus.en_vps3     = en_c[2];
    assign bus.en_vps4     = en_c[3];
    assign bus.clear_vps1  = clr_c[0];
    assign bus.clear_vps2  = clr_c[1];
    assign bus.clear_vps3  = clr_c[2];
    assign bus.clear_vps4  = clr_c[3];
    assign bus.fwd_a       = rst_n ? fwd_a_raw : FWD_RF;
    assign bus.fwd_b       = rst_n ? fwd_b_raw : FWD_RF;
    assign bus.halted      = rst_n && !active;
    assign bus.timeout_err = timeout_err_q;
    assign bus.state       = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             stall_inc, flush_inc;

    assign stall_inc = bus.en && active && !pc_en_c;
    assign flush_inc = bus.en && active && !bus.mem_busy && bus.ex_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table for the
// combinational hazard/forwarding decode plus multi-cycle stall sequences.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    // {pc_en, en_vps1..4, clear_vps1..4, fwd_a, fwd_b, halted, timeout_err}
    localparam logic [14:0] O_RST   = 15'b0_0000_0000_00_00_0_0;
    localparam logic [14:0] O_IDLE  = 15'b1_1111_1111_00_00_0_0;
    localparam logic [14:0] O_LU    = 15'b0_0111_1011_00_00_0_0;
    localparam logic [14:0] O_REDIR = 15'b1_1111_0011_00_00_0_0;
    localparam logic [14:0] O_MW    = 15'b0_0001_1110_00_00_0_0;
    localparam logic [14:0] O_FRZ   = 15'b0_0000_1111_00_00_0_0;
    localparam logic [14:0] O_HLT   = 15'b0_0000_1111_00_00_1_0;
    localparam logic [14:0] O_HLTE  = 15'b0_0000_1111_00_00_1_1;

    typedef struct {
        logic [4:0]  id_rs1, id_rs2;
        logic        use1, use2;
        logic [4:0]  ex_rd;
        logic        ld, redir;
        logic [4:0]  mem_rd;
        logic        mem_rw;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic [4:0]  ex_rs1, ex_rs2;
        logic [14:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic [14:0] exp_q[$];
    vec_t vecs[12];

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();

    pipeline_hazard_ctrl #(.REG_AW(5), .TIMEOUT(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkv(input logic [4:0] id_rs1, input logic [4:0] id_rs2,
                                 input logic use1, input logic use2,
                                 input logic [4:0] ex_rd, input logic ld, input logic redir,
                                 input logic [4:0] mem_rd, input logic mem_rw,
                                 input logic [4:0] wb_rd, input logic wb_rw,
                                 input logic [4:0] ex_rs1, input logic [4:0] ex_rs2,
                                 input logic [14:0] exp);
        vec_t v;
        v.id_rs1 = id_rs1; v.id_rs2 = id_rs2; v.use1 = use1; v.use2 = use2;
        v.ex_rd = ex_rd; v.ld = ld; v.redir = redir;
        v.mem_rd = mem_rd; v.mem_rw = mem_rw; v.wb_rd = wb_rd; v.wb_rw = wb_rw;
        v.ex_rs1 = ex_rs1; v.ex_rs2 = ex_rs2; v.exp = exp;
        return v;
    endfunction

    function automatic logic [14:0] observed();
        return {bus.pc_en, bus.en_vps1, bus.en_vps2, bus.en_vps3, bus.en_vps4,
                bus.clear_vps1, bus.clear_vps2, bus.clear_vps3, bus.clear_vps4,
                bus.fwd_a, bus.fwd_b, bus.halted, bus.timeout_err};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rd = '0; bus.ex_is_load = 1'b0; bus.ex_redirect = 1'b0;
        bus.mem_rd = '0; bus.wb_rd = '0; bus.mem_regwrite = 1'b0; bus.wb_regwrite = 1'b0;
        bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.mem_busy = 1'b0; bus.wb_halt = 1'b0;
        bus.en = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v);
        bus.id_rs1 = v.id_rs1; bus.id_rs2 = v.id_rs2;
        bus.id_use_rs1 = v.use1; bus.id_use_rs2 = v.use2;
        bus.ex_rd = v.ex_rd; bus.ex_is_load = v.ld; bus.ex_redirect = v.redir;
        bus.mem_rd = v.mem_rd; bus.mem_regwrite = v.mem_rw;
        bus.wb_rd = v.wb_rd; bus.wb_regwrite = v.wb_rw;
        bus.ex_rs1 = v.ex_rs1; bus.ex_rs2 = v.ex_rs2;
    endtask

    // Expected value enters the queue with the stimulus; compared at the falling edge.
    task automatic chk(input string name, input logic [14:0] exp);
        logic [14:0] got;
        logic [14:0] want;
        exp_q.push_back(exp);
        @(negedge clk);
        got  = observed();
        want = exp_q.pop_front();
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic chk_state(input string name, input logic [1:0] exp);
        n_chk++;
        if (bus.state !== exp) begin
            n_fail++;
            $display("FAIL %s: state got %0d expected %0d", name, bus.state, exp);
        end
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n = 1'b0;
        idle_inputs();
        chk("reset_out", O_RST);
        next_cycle();
        rst_n = 1'b1;
        chk("reset_release", O_IDLE);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_inputs();

        vecs[0]  = mkv(5'd1, 5'd2,  1, 1, 5'd3,  0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, O_IDLE);
        vecs[1]  = mkv(5'd5, 5'd6,  1, 1, 5'd5,  1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, O_LU);
        vecs[2]  = mkv(5'd1, 5'd12, 1, 0, 5'd12, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, O_IDLE);
        vecs[3]  = mkv(5'd0, 5'd0,  1, 1, 5'd0,  1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, O_IDLE);
        vecs[4]  = mkv(5'd5, 5'd6,  1, 1, 5'd5,  0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, O_IDLE);
        vecs[5]  = mkv(5'd5, 5'd6,  1, 1, 5'd5,  1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, O_REDIR);
        vecs[6]  = mkv(5'd0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd7, 1, 5'd7, 1, 5'd7, 5'd0,
                       15'b1_1111_1111_10_00_0_0);
        vecs[7]  = mkv(5'd0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd0, 1, 5'd7, 1, 5'd7, 5'd0,
                       15'b1_1111_1111_01_00_0_0);
        vecs[8]  = mkv(5'd0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd0, 1, 5'd0, 1, 5'd0, 5'd0, O_IDLE);
        vecs[9]  = mkv(5'd0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd3, 0, 5'd3, 1, 5'd1, 5'd3,
                       15'b1_1111_1111_00_01_0_0);
        vecs[10] = mkv(5'd0, 5'd0,  0, 0, 5'd0,  0, 0, 5'd9, 1, 5'd4, 1, 5'd4, 5'd9,
                       15'b1_1111_1111_01_10_0_0);
        vecs[11] = mkv(5'd1, 5'd12, 0, 1, 5'd12, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'd0, O_LU);

        next_cycle();
        chk("reset_out", O_RST);
        chk_state("reset_state", RUN);
        next_cycle();
        rst_n = 1'b1;
        chk("idle_after_reset", O_IDLE);

        for (int i = 0; i < 12; i++) begin
            next_cycle();
            apply_vec(vecs[i]);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Load-use lasts one cycle: the load then moves on to MEM.
        next_cycle();
        idle_inputs();
        bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
        chk("lu_stall", O_LU);
        next_cycle();
        bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0;
        chk("lu_release", O_IDLE);

        // Three busy cycles, then back to RUN with no fault.
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            bus.mem_busy = 1'b1;
            chk($sformatf("mw_busy%0d", k), O_MW);
        end
        next_cycle();
        bus.mem_busy = 1'b0;
        chk_state("mw_state", MEM_WAIT);
        chk("mw_exit", O_IDLE);
        next_cycle();
        chk_state("mw_back_run", RUN);
        chk("mw_after", O_IDLE);

        // Exit cycle from MEM_WAIT honours a redirect.
        next_cycle();
        bus.mem_busy = 1'b1;
        chk("mw2_busy", O_MW);
        next_cycle();
        bus.mem_busy = 1'b0; bus.ex_redirect = 1'b1;
        chk("mw2_exit_redirect", O_REDIR);
        next_cycle();
        bus.ex_redirect = 1'b0;
        chk_state("mw2_run", RUN);

        // Timeout after four busy cycles, sticky until reset.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            bus.mem_busy = 1'b1;
            chk($sformatf("to_busy%0d", k), O_MW);
        end
        next_cycle();
        bus.mem_busy = 1'b0;
        chk("to_halted", O_HLTE);
        next_cycle();
        bus.ex_redirect = 1'b1;
        chk("to_sticky", O_HLTE);
        next_cycle();
        rst_n = 1'b0;
        chk("to_reset", O_RST);
        chk_state("to_reset_state", RUN);
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
        chk("to_cleared", O_IDLE);

        // Halt pulse.
        next_cycle();
        bus.wb_halt = 1'b1;
        chk("halt_pulse", O_IDLE);
        next_cycle();
        bus.wb_halt = 1'b0;
        chk("halt_entered", O_HLT);
        next_cycle();
        bus.mem_busy = 1'b1; bus.ex_redirect = 1'b1;
        chk("halt_held", O_HLT);
        do_reset();

        // Halt beats a concurrent memory wait.
        next_cycle();
        bus.wb_halt = 1'b1; bus.mem_busy = 1'b1;
        chk("halt_busy_same", O_MW);
        next_cycle();
        idle_inputs();
        chk("halt_over_busy", O_HLT);
        do_reset();

        // en=0 during MEM_WAIT freezes wait_cnt.
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            bus.mem_busy = 1'b1;
            chk($sformatf("frz_busy%0d", k), O_MW);
        end
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            bus.en = 1'b0;
            chk($sformatf("frz_off%0d", k), O_FRZ);
        end
        next_cycle();
        bus.en = 1'b1;
        chk("frz_resume", O_MW);
        next_cycle();
        chk("frz_no_timeout", O_MW);
        next_cycle();
        bus.mem_busy = 1'b0;
        chk("frz_timeout", O_HLTE);
        do_reset();

        // Reset in the middle of MEM_WAIT leaves no stall behind.
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            bus.mem_busy = 1'b1;
            chk($sformatf("rmw_busy%0d", k), O_MW);
        end
        next_cycle();
        rst_n = 1'b0;
        chk("rmw_reset", O_RST);
        chk_state("rmw_state", RUN);
        next_cycle();
        rst_n = 1'b1;
        bus.mem_busy = 1'b0;
        chk("rmw_idle", O_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage RV32 pipeline core.
- Drives `en_vps1..4` (active-high hold-release) and `clear_vps1..4` (active-low synchronous flush) of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus `pc_en`.
- Detects load-use, taken-branch/jump, memory-wait and halt conditions; generates EX operand forwarding selects.
- Instantiated once in the core top, replacing the constant `en_vpsN`/`clear_vpsN` tie-offs.

Parameters:
- `REG_AW`, 5, register address width.
- `TIMEOUT`, 255, maximum consecutive `mem_busy` cycles before fault; 1..65535.
- `CNT_W`, 16, width of the wait counter and of the optional perf counters.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  global core enable; 0 freezes the pipeline and all internal state
- `id_rs1, id_rs2`  in  REG_AW each  ID-stage source register addresses
- `id_use_rs1, id_use_rs2`  in  1 each  ID instruction actually reads rs1/rs2
- `ex_rd`  in  REG_AW  EX-stage destination register
- `ex_is_load`  in  1  EX instruction is a load
- `ex_redirect`  in  1  EX resolved a taken branch or jump
- `mem_rd, wb_rd`  in  REG_AW each  MEM/WB-stage destination registers
- `mem_regwrite, wb_regwrite`  in  1 each  MEM/WB write the register file
- `ex_rs1, ex_rs2`  in  REG_AW each  EX-stage source addresses
- `mem_busy`  in  1  data memory not ready; MEM must hold
- `wb_halt`  in  1  ecall/ebreak retiring in WB
- `pc_en`  out  1  PC update enable
- `en_vps1..en_vps4`  out  1 each  pipeline register load enables
- `clear_vps1..clear_vps4`  out  1 each  pipeline register flush, active-low
- `fwd_a, fwd_b`  out  2 each  EX operand select: 00 register file, 01 WB, 10 MEM
- `halted`  out  1  core halted
- `timeout_err`  out  1  sticky memory-timeout fault

Behaviour:
- **Reset.** While `rst_n`=0, outputs are forced as follows:
  - 0: `en_vps*`, `clear_vps*` (pipeline flushed), `pc_en`, `fwd_*`, `halted`, `timeout_err`.
  - Internal: state=RUN, wait_cnt=0.
- **Registered state.** FSM state {RUN, MEM_WAIT, HALT}, `wait_cnt`, `timeout_err`. All other outputs are combinational from state and inputs.
- **Global enable.** `en`=0: all `en_vps*`=0, `pc_en`=0, `clear_vps*`=1, and no register updates. `en` overrides every condition below.
- **Idle.** RUN with no hazard: all enables=1, all clears=1.
- **Priority** (highest first): HALT > `mem_busy` > `ex_redirect` > load-use.
- **Load-use** (RUN): `ex_is_load` & `ex_rd`≠0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
  - `pc_en`=0, `en_vps1`=0, `clear_vps2`=0 (bubble into EX).
  - Self-clears after exactly 1 cycle because the load advances to MEM.
- **Redirect** (RUN): `pc_en`=1, `clear_vps1`=0, `clear_vps2`=0. Two-instruction flush, same cycle. Redirect suppresses a simultaneous load-use.
- **Memory wait.** `mem_busy`=1 in RUN → MEM_WAIT on the next edge.
  - Combinationally in that same cycle, and in every MEM_WAIT cycle with `mem_busy`=1: `pc_en`=0, `en_vps1..3`=0, `en_vps4`=1, `clear_vps4`=0 (bubble into WB).
  - `wait_cnt` increments each busy cycle.
  - `mem_busy`=0 in MEM_WAIT → RUN, wait_cnt=0. That cycle behaves as RUN, including redirect and load-use evaluation.
- **Timeout.** wait_cnt reaches TIMEOUT → `timeout_err`=1 (sticky) and state → HALT.
- **Halt.** `wb_halt`=1 in any non-HALT state → HALT on the next edge.
  - HALT: `halted`=1, all enables=0, all clears=1. Exit only via reset.
  - `wb_halt` concurrent with `mem_busy`: halt wins.
- **Forwarding** (independent of state), computed for `fwd_a` and likewise for `fwd_b` with `ex_rs2`:
  - `fwd_a`=10 if `mem_regwrite` & `mem_rd`≠0 & `mem_rd`==`ex_rs1`;
  - else 01 if `wb_regwrite` & `wb_rd`≠0 & `wb_rd`==`ex_rs1`;
  - else 00.
  - MEM has priority over WB. x0 is never forwarded.
- **Reset mid-operation.** Reset asserted during MEM_WAIT or HALT returns immediately to reset values; there is no residual stall.

Optional Feature:
- Macro: `HAZARD_PERF_CNT_EN`.
- Defined: adds outputs `perf_stall_cnt`, `perf_flush_cnt`, each CNT_W wide, reset 0, saturating at all-ones.
  - `perf_stall_cnt` +1 per cycle with `pc_en`=0 while in RUN or MEM_WAIT with `en`=1.
  - `perf_flush_cnt` +1 per applied redirect.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package `hazard_pkg`:
  - state enum {RUN, MEM_WAIT, HALT};
  - `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10;
  - `CLR_ACTIVE`=1'b0.
- Sub-module `fwd_unit` (combinational forwarding compare, one instance per operand).
- FSM and stall/flush logic stay in the top.

Test Plan:
- **Load-use:** `lw` to x5 in EX, ID `add` using x5 → exactly 1 cycle with `pc_en`=0, `en_vps1`=0, `clear_vps2`=0; then all 1.
- **Redirect with load-use:** `ex_redirect`=1 with a concurrent load-use match → `clear_vps1`=`clear_vps2`=0, `pc_en`=1, no stall.
- **Memory wait:** `mem_busy` held for 3 cycles → `en_vps1..3`=0 and `clear_vps4`=0 for 3 cycles, then RUN; `timeout_err`=0.
- **Timeout:** TIMEOUT=4, `mem_busy` held → `timeout_err`=1 and `halted`=1 after 4 busy cycles; stays set until `rst_n`=0.
- **Forwarding:** `ex_rs1`=`mem_rd`=`wb_rd`=7, both regwrite=1 → `fwd_a`=10; `mem_rd`=0 → 01; `ex_rs1`=0 → 00.
- **Halt and enable:** `wb_halt` pulse → `halted`=1, all `en_vps*`=0 next cycle. Separately, `en`=0 during MEM_WAIT → wait_cnt frozen.
